reg_space_apb_master: RTL

//   APB4 requester: converts single-outstanding valid/ready req/rsp transactions into APB4 SETUP/ACCESS

---
 rtl/reg_space_apb_master.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/reg_space_apb_master.sv
// rtl/reg_space_apb_master.sv - single-outstanding req/rsp to APB4 requester with ACCESS timeout
module reg_space_apb_master #(
    parameter int          ADDR_W      = 16,
    parameter logic [2:0]  PROT        = 3'b000,
    parameter int          TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_strb,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] p_addr,
    output logic [2:0]        p_prot,
    output logic              p_sel,
    output logic              p_enable,
    output logic              p_write,
    output logic [31:0]       p_wdata,
    output logic [3:0]        p_strb,
    input  logic              p_ready,
    input  logic [31:0]       p_rdata,
    input  logic              p_slverr
);
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] LP_CNT_MAX  = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

    state_t            r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_req_rdy, w_req_rdy;
    logic              r_rsp_vld, w_rsp_vld;
    logic [31:0]       r_rsp_rdata, w_rsp_rdata;
    logic              r_rsp_slverr, w_rsp_slverr;
    logic              r_rsp_timeout, w_rsp_timeout;
    logic [ADDR_W-1:0] r_p_addr, w_p_addr;
    logic              r_p_sel, w_p_sel;
    logic              r_p_enable, w_p_enable;
    logic              r_p_write, w_p_write;
    logic [31:0]       r_p_wdata, w_p_wdata;
    logic [3:0]        r_p_strb, w_p_strb;

    // Next-state logic computes the next value of every output so all outputs leave a flop.
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_req_rdy     = r_req_rdy;
        w_rsp_vld     = r_rsp_vld;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_slverr  = r_rsp_slverr;
        w_rsp_timeout = r_rsp_timeout;
        w_p_addr      = r_p_addr;
        w_p_sel       = r_p_sel;
        w_p_enable    = r_p_enable;
        w_p_write     = r_p_write;
        w_p_wdata     = r_p_wdata;
        w_p_strb      = r_p_strb;
        case (r_state)
            ST_IDLE: begin
                if (req_vld && r_req_rdy) begin
                    w_state   = ST_SETUP;
                    w_req_rdy = 1'b0;
                    w_cnt     = '0;
                    w_p_sel   = 1'b1;
                    w_p_addr  = {req_addr[ADDR_W-1:2], 2'b00};
                    w_p_write = req_write;
                    w_p_wdata = req_write ? req_wdata : 32'h0;
                    w_p_strb  = req_write ? req_strb : 4'h0;
                end
            end
            ST_SETUP: begin
                w_state    = ST_ACCESS;
                w_p_enable = 1'b1;
            end
            ST_ACCESS: begin
                if (p_ready) begin
                    w_state       = ST_RESP;
                    w_p_sel       = 1'b0;
                    w_p_enable    = 1'b0;
                    w_rsp_vld     = 1'b1;
                    w_rsp_rdata   = r_p_write ? 32'h0 : p_rdata;
                    w_rsp_slverr  = p_slverr;
                    w_rsp_timeout = 1'b0;
                end else if ((TIMEOUT_CYC != 0) && (r_cnt == LP_CNT_LAST)) begin
                    w_state       = ST_RESP;
                    w_cnt         = LP_CNT_MAX;
                    w_p_sel       = 1'b0;
                    w_p_enable    = 1'b0;
                    w_rsp_vld     = 1'b1;
                    w_rsp_rdata   = 32'h0;
                    w_rsp_slverr  = 1'b1;
                    w_rsp_timeout = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_rdy) begin
                    w_state   = ST_IDLE;
                    w_rsp_vld = 1'b0;
                    w_req_rdy = 1'b1;
                end
            end
            default: begin
                w_state   = ST_IDLE;
                w_req_rdy = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_req_rdy     <= 1'b1;
            r_rsp_vld     <= 1'b0;
            r_rsp_rdata   <= 32'h0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_p_addr      <= '0;
            r_p_sel       <= 1'b0;
            r_p_enable    <= 1'b0;
            r_p_write     <= 1'b0;
            r_p_wdata     <= 32'h0;
            r_p_strb      <= 4'h0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_req_rdy     <= w_req_rdy;
            r_rsp_vld     <= w_rsp_vld;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_slverr  <= w_rsp_slverr;
            r_rsp_timeout <= w_rsp_timeout;
            r_p_addr      <= w_p_addr;
            r_p_sel       <= w_p_sel;
            r_p_enable    <= w_p_enable;
            r_p_write     <= w_p_write;
            r_p_wdata     <= w_p_wdata;
            r_p_strb      <= w_p_strb;
        end
    end

    assign req_rdy     = r_req_rdy;
    assign rsp_vld     = r_rsp_vld;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_slverr  = r_rsp_slverr;
    assign rsp_timeout = r_rsp_timeout;
    assign p_addr      = r_p_addr;
    assign p_prot      = PROT;
    assign p_sel       = r_p_sel;
    assign p_enable    = r_p_enable;
    assign p_write     = r_p_write;
    assign p_wdata     = r_p_wdata;
    assign p_strb      = r_p_strb;
endmodule
